fixed_point_accumulator: RTL and testbench
==========================================

// Module: fixed_point_accumulator
// PURPOSE
//  Block accumulator fed directly by the sign-magnitude fixed-point adder path.
//  Consumes a valid/ready stream of N-bit sign-magnitude samples and sums LEN of them with saturation.
//  Presents the block sum on a valid/ready output, then restarts for the next block.
//  Downstream-of-adder stage for windowed sums (moving-average/energy front ends).
// PARAMETERS
//  Q     4   fractional bits; informational only, arithmetic is format-agnostic
//  N     8   total width: bit N-1 = sign, bits N-2:0 = magnitude
//  LEN   4   samples per block, >=1
//  CNT_W 3   counter width, must hold LEN ($clog2(LEN)+1)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  clear      in   1  synchronous abort: discard partial block
//  in_valid   in   1  in_data is valid
//  in_ready   out  1  block accepts a sample this cycle
//  in_data    in   N  sign-magnitude sample
//  out_valid  out  1  block sum available
//  out_ready  in   1  consumer takes the sum
//  out_data   out  N  sign-magnitude block sum
//  out_sat    out  1  at least one saturation occurred in this block
// BEHAVIOUR
//  Reset (async): state=ACC, acc=+0, cnt=0, sat=0; out_valid=0, out_data=0, out_sat=0, in_ready=1.
//  FSM: ACC  -> in_ready=1, out_valid=0; each accepted sample (in_valid&&in_ready): acc<=acc+in_data, cnt++.
//       ACC  -> HOLD on acceptance of the LEN-th sample.
//       HOLD -> in_ready=0, out_valid=1; out_data/out_sat are the registered result and stay stable.
//       HOLD -> ACC on out_valid&&out_ready; acc=+0, cnt=0, sat=0 in that same edge.
//  Latency: out_valid rises the cycle after the edge that accepts the LEN-th sample.
//  No same-cycle bypass: a sample arriving during HOLD is stalled (in_ready=0), never dropped.
//  Arithmetic (sign-magnitude, N-1 bit magnitudes):
//   equal signs: mag=|a|+|b|; carry out of N-1 bits -> mag=2^(N-1)-1, keep sign, sat<=1.
//   opposite signs: mag=larger-smaller, sign of larger; equal magnitudes -> +0.
//   -0 input (0x80 at N=8) is treated as +0; -0 never appears on out_data.
//  out_sat is sticky within a block; it clears only on output handshake, clear, or rst.
//  Saturation is not unwound: later opposite-sign samples subtract from the clamped value.
//  clear: highest synchronous priority, in ACC or HOLD. Next edge: ACC, acc=+0, cnt=0, sat=0.
//   A sample presented with clear is not accepted; a HOLD result is discarded without handshake.
//  rst mid-operation: immediate return to the reset state; the partial block is lost.
//  LEN=1: every accepted sample goes straight to HOLD; out_data equals the normalised sample.
// STRUCTURE
//  Shared package fxp_pkg: sign/magnitude field localparams, the MAG_MAX constant, and the state encoding (ACC, HOLD).
//  One sub-module: fxp_sm_sat_add. It is combinational: a, b -> sum, sat.
//   It provides the sign-magnitude add with saturation and -0 normalisation, and can be tested standalone.
//  Top level holds the FSM, counter, acc/sat registers and handshake logic.
// TESTING (N=8, LEN=4 unless noted)
//  1 Samples 0x05,0x05,0x05,0x05 with out_ready=1 -> one out_valid pulse, out_data=0x14, out_sat=0.
//  2 Samples 0x10,0x83,0x82,0x01 (16,-3,-2,+1) -> out_data=0x0C, out_sat=0.
//  3 Samples 0x7F,0x01,0x81,0x00 -> clamp at 0x7F, then 0x7E; out_data=0x7E, out_sat=1.
//  4 Samples 0x85,0x05,0x80,0x00 -> out_data=0x00 (not 0x80), out_sat=0.
//  5 Case 1 with out_ready=0 for 5 cycles, in_valid held high:
//     -> out_data stable, in_ready=0 throughout; after the handshake the next block starts from +0.
//  6 rst pulse after 2 of 4 samples (repeat with clear):
//     -> outputs return to reset values; next 4x 0x01 give out_data=0x04.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point accumulator slice.
// Sign/magnitude field layout, magnitude ceiling and FSM encoding.
package fxp_pkg;

   localparam int N_DEF    = 8;
   localparam int SIGN_BIT = N_DEF - 1;
   localparam int MAG_W    = N_DEF - 1;
   localparam int MAG_MAX  = (1 << MAG_W) - 1;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/fixed_point_accumulator_if.sv
// Sample stream in, block sum out, both valid/ready.
// master drives samples and takes sums; slave is the accumulator.
interface fixed_point_accumulator_if #(
   parameter int N = fxp_pkg::N_DEF
);

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         out_sat;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sat
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sat
   );

endinterface

// File: rtl/fxp_sm_sat_add.sv
// Combinational sign-magnitude adder with saturation.
// Negative zero on either input is read as +0 and never produced.
module fxp_sm_sat_add #(
   parameter int N = fxp_pkg::N_DEF
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         sat
);

   localparam logic [N-2:0] MAX_MAG = '1;

   logic [N-2:0] a_mag;
   logic [N-2:0] b_mag;
   logic         a_neg;
   logic         b_neg;
   logic [N-1:0] wide;
   logic [N-2:0] mag;
   logic         neg;

   // Split fields and fold -0 onto +0
   always_comb begin
      a_mag = a[N-2:0];
      b_mag = b[N-2:0];
      a_neg = a[N-1] && (a_mag != '0);
      b_neg = b[N-1] && (b_mag != '0);
   end

   // Add or subtract magnitudes, clamp on carry, normalise zero
   always_comb begin
      wide = {1'b0, a_mag} + {1'b0, b_mag};
      mag  = '0;
      neg  = 1'b0;
      sat  = 1'b0;
      if (a_neg == b_neg) begin
         neg = a_neg;
         if (wide[N-1]) begin
            mag = MAX_MAG;
            sat = 1'b1;
         end else begin
            mag = wide[N-2:0];
         end
      end else if (a_mag >= b_mag) begin
         mag = a_mag - b_mag;
         neg = a_neg;
      end else begin
         mag = b_mag - a_mag;
         neg = b_neg;
      end
      if (mag == '0) begin
         neg = 1'b0;
      end
      sum = {neg, mag};
   end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Saturating block accumulator over a sign-magnitude sample stream.
// Sums LEN samples, holds the result until taken, then restarts.
module fixed_point_accumulator
   import fxp_pkg::*;
#(
   parameter int Q     = 4,
   parameter int N     = 8,
   parameter int LEN   = 4,
   parameter int CNT_W = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   fixed_point_accumulator_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   state_t           state_q;
   state_t           state_d;
   logic [N-1:0]     acc_q;
   logic             sat_q;
   logic [CNT_W-1:0] cnt_q;
   logic [N-1:0]     add_sum;
   logic             add_sat;
   logic             accept;
   logic             take;

   fxp_sm_sat_add #(
      .N (N)
   ) u_add (
      .a   (acc_q),
      .b   (bus.in_data),
      .sum (add_sum),
      .sat (add_sat)
   );

   // A sample presented together with clear is refused
   always_comb begin
      accept = (state_q == ACC) && bus.in_valid && !clear;
      take   = (state_q == HOLD) && bus.out_ready;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACC;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: clear beats everything, then fill/drain
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ACC;
      end else begin
         unique case (state_q)
            ACC: begin
               if (accept && (cnt_q == LAST)) begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (take) begin
                  state_d = ACC;
               end
            end
            default: state_d = ACC;
         endcase
      end
   end

   // Outputs are straight from state and result registers
   always_comb begin
      bus.in_ready  = (state_q == ACC);
      bus.out_valid = (state_q == HOLD);
      bus.out_data  = acc_q;
      bus.out_sat   = sat_q;
   end

   // Running sum, sticky saturation flag and sample count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         sat_q <= 1'b0;
         cnt_q <= '0;
      end else if (clear || take) begin
         acc_q <= '0;
         sat_q <= 1'b0;
         cnt_q <= '0;
      end else if (accept) begin
         acc_q <= add_sum;
         sat_q <= sat_q | add_sat;
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Directed bench for the block accumulator at N=8, LEN=4.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_fixed_point_accumulator;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   int   checks   = 0;
   int   failures = 0;

   fixed_point_accumulator_if #(.N(8)) bus ();

   fixed_point_accumulator #(
      .Q     (4),
      .N     (8),
      .LEN   (4),
      .CNT_W (3)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one sample at a falling edge; returns at the next one
   task automatic send(input logic [7:0] d);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("send_timeout", 0, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_hold(input string tag, input logic [7:0] d,
                              input logic s);
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_ready"}, bus.in_ready, 0);
      chk({tag, "_data"}, bus.out_data, d);
      chk({tag, "_sat"}, bus.out_sat, s);
   endtask

   task automatic drain(input string tag);
      @(negedge clk);
      chk({tag, "_done"}, bus.out_valid, 0);
      chk({tag, "_restart"}, bus.in_ready, 1);
   endtask

   initial begin
      rst           = 1'b1;
      clear         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", bus.out_data, 8'h00);
      chk("rst_sat", bus.out_sat, 0);
      chk("rst_ready", bus.in_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      // 1: plain sum
      send(8'h05); send(8'h05); send(8'h05); send(8'h05);
      expect_hold("t1", 8'h14, 0);
      drain("t1");

      // 2: mixed signs
      send(8'h10); send(8'h83); send(8'h82); send(8'h01);
      expect_hold("t2", 8'h0C, 0);
      drain("t2");

      // 3: clamp then subtract from the clamp
      send(8'h7F); send(8'h01);
      chk("t3_clamp", bus.out_data, 8'h7F);
      chk("t3_sticky", bus.out_sat, 1);
      send(8'h81); send(8'h00);
      expect_hold("t3", 8'h7E, 1);
      drain("t3");
      chk("t3_sat_clr", bus.out_sat, 0);

      // 4: cancellation and -0 input
      send(8'h85); send(8'h05); send(8'h80); send(8'h00);
      expect_hold("t4", 8'h00, 0);
      drain("t4");

      // 5: back-pressure with a waiting sample
      bus.out_ready = 1'b0;
      send(8'h05); send(8'h05); send(8'h05); send(8'h05);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      for (int i = 0; i < 5; i++) begin
         expect_hold("t5_stall", 8'h14, 0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("t5_done", bus.out_valid, 0);
      chk("t5_zero", bus.out_data, 8'h00);
      chk("t5_ready", bus.in_ready, 1);
      @(negedge clk);
      chk("t5_first", bus.out_data, 8'h01);
      send(8'h01); send(8'h01); send(8'h01);
      expect_hold("t5_next", 8'h04, 0);
      drain("t5");

      // 6a: async reset mid-block
      send(8'h01); send(8'h01);
      chk("t6_part", bus.out_data, 8'h02);
      rst = 1'b1;
      #1;
      chk("t6_rst_data", bus.out_data, 8'h00);
      chk("t6_rst_valid", bus.out_valid, 0);
      chk("t6_rst_ready", bus.in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(8'h01); send(8'h01); send(8'h01); send(8'h01);
      expect_hold("t6_rst", 8'h04, 0);
      drain("t6_rst");

      // 6b: clear mid-block, sample offered with clear is refused
      send(8'h01); send(8'h7F); send(8'h7F);
      chk("t6_sat_pre", bus.out_sat, 1);
      clear        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      @(negedge clk);
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      chk("t6_clr_data", bus.out_data, 8'h00);
      chk("t6_clr_sat", bus.out_sat, 0);
      chk("t6_clr_ready", bus.in_ready, 1);
      send(8'h01); send(8'h01); send(8'h01); send(8'h01);
      expect_hold("t6_clr", 8'h04, 0);
      drain("t6_clr");

      // 6c: clear discards a held result
      bus.out_ready = 1'b0;
      send(8'h02); send(8'h02); send(8'h02); send(8'h02);
      expect_hold("t6_hold", 8'h08, 0);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      bus.out_ready = 1'b1;
      chk("t6_hclr_valid", bus.out_valid, 0);
      chk("t6_hclr_data", bus.out_data, 8'h00);
      send(8'h83); send(8'h01); send(8'h01); send(8'h01);
      expect_hold("t6_after", 8'h00, 0);
      drain("t6_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
